nacifra_cipher_encoder: RTL and testbench



---
 rtl/nacifra_cipher_encoder.sv | 188 ++++++++++++++++++
 tb/tb_nacifra_cipher_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nacifra_cipher_encoder.sv
// nacifra_cipher_encoder
// Caesar-cipher encoder for the Nacifra display path. A BCD digit is loaded
// into a 5-bit Johnson code register. The register is then stepped forward
// (encrypt) or backward (decrypt) one position per clock, key times. The
// binary result counter wraps 9<->0 in lockstep with the code.
module nacifra_cipher_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit,
    input  logic [3:0] key,
    input  logic       decrypt,
    output logic       s5,
    output logic       s4,
    output logic       s3,
    output logic       s2,
    output logic       s1,
    output logic [3:0] result,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Pattern shown for rejected operands. It is not a Johnson code, so the
    // downstream converter displays its invalid glyph.
    localparam logic [4:0] INVALID_CODE = 5'b01010;

    state_t     state_r, state_next_s;
    logic [4:0] code_r, code_next_s;
    logic [3:0] result_r, result_next_s;
    logic [3:0] cnt_r, cnt_next_s;
    logic       dir_r, dir_next_s;
    logic       busy_r, busy_next_s;
    logic       done_r, done_next_s;
    logic       err_r, err_next_s;
    logic       operands_ok_s;
    logic       accept_s;
    logic       reject_s;

    // Johnson code for a BCD digit. Out-of-range digits map to the invalid pattern.
    function automatic logic [4:0] nacifra_code(input logic [3:0] d);
        logic [4:0] c;
        case (d)
            4'd0:    c = 5'b10000;
            4'd1:    c = 5'b11000;
            4'd2:    c = 5'b11100;
            4'd3:    c = 5'b11110;
            4'd4:    c = 5'b11111;
            4'd5:    c = 5'b01111;
            4'd6:    c = 5'b00111;
            4'd7:    c = 5'b00011;
            4'd8:    c = 5'b00001;
            4'd9:    c = 5'b00000;
            default: c = INVALID_CODE;
        endcase
        return c;
    endfunction

    // One position forward on the twisted ring. Bit 4 is s5 and bit 0 is s1.
    function automatic logic [4:0] step_fwd(input logic [4:0] c);
        return {~c[0], c[4:1]};
    endfunction

    // One position backward on the twisted ring.
    function automatic logic [4:0] step_bwd(input logic [4:0] c);
        return {c[3:0], ~c[4]};
    endfunction

    // Modulo-10 increment of the binary result.
    function automatic logic [3:0] inc_mod10(input logic [3:0] r);
        return (r == 4'd9) ? 4'd0 : r + 4'd1;
    endfunction

    // Modulo-10 decrement of the binary result.
    function automatic logic [3:0] dec_mod10(input logic [3:0] r);
        return (r == 4'd0) ? 4'd9 : r - 4'd1;
    endfunction

    assign operands_ok_s = (digit <= 4'd9) && (key <= 4'd9);
    assign accept_s      = (state_r == ST_IDLE) && start && operands_ok_s;
    assign reject_s      = (state_r == ST_IDLE) && start && !operands_ok_s;

    // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> DONE when the count is exhausted, DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and output next values: load, step or hold the code, result, count and direction.
    always_comb begin
        code_next_s   = code_r;
        result_next_s = result_r;
        cnt_next_s    = cnt_r;
        dir_next_s    = dir_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    code_next_s   = nacifra_code(digit);
                    result_next_s = digit;
                    cnt_next_s    = key;
                    dir_next_s    = decrypt;
                end else if (reject_s) begin
                    code_next_s   = INVALID_CODE;
                    result_next_s = 4'hF;
                end else begin
                    code_next_s   = code_r;
                    result_next_s = result_r;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != 4'd0) begin
                    if (dir_r) begin
                        code_next_s   = step_bwd(code_r);
                        result_next_s = dec_mod10(result_r);
                    end else begin
                        code_next_s   = step_fwd(code_r);
                        result_next_s = inc_mod10(result_r);
                    end
                    cnt_next_s = cnt_r - 4'd1;
                end else begin
                    cnt_next_s = 4'd0;
                end
            end
            ST_DONE: begin
                cnt_next_s = 4'd0;
            end
            default: begin
                cnt_next_s = 4'd0;
            end
        endcase
        busy_next_s = (state_next_s == ST_SHIFT);
        done_next_s = (state_next_s == ST_DONE);
        err_next_s  = reject_s;
    end

    // State and output registers. The synchronous reset overrides any coincident start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            code_r   <= 5'b10000;
            result_r <= 4'd0;
            cnt_r    <= 4'd0;
            dir_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            code_r   <= code_next_s;
            result_r <= result_next_s;
            cnt_r    <= cnt_next_s;
            dir_r    <= dir_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
            err_r    <= err_next_s;
        end
    end

    assign {s5, s4, s3, s2, s1} = code_r;
    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;

endmodule

// File: tb/tb_nacifra_cipher_encoder.sv
// Scoreboard testbench for nacifra_cipher_encoder. The stimulus process
// pushes an expected outcome for every request. The monitor pops and compares
// whenever done or err is presented. While busy, the monitor also checks that
// the displayed code tracks the result.
module tb_nacifra_cipher_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] digit;
    logic [3:0] key;
    logic       decrypt;
    logic       s5, s4, s3, s2, s1;
    logic [3:0] result;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        logic [4:0] code;
        logic [3:0] res;
        int         busy_len;
    } exp_t;

    exp_t sb[$];

    logic [4:0] tbl [10] = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
                             5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};

    wire [4:0] code = {s5, s4, s3, s2, s1};

    nacifra_cipher_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .digit   (digit),
        .key     (key),
        .decrypt (decrypt),
        .s5      (s5),
        .s4      (s4),
        .s3      (s3),
        .s2      (s2),
        .s1      (s1),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: modular Caesar shift on the digit value.
    function automatic exp_t model(input int d, input int k, input bit dec);
        exp_t e;
        int   r;
        if (d > 9 || k > 9) begin
            e.is_err   = 1'b1;
            e.code     = 5'b01010;
            e.res      = 4'hF;
            e.busy_len = 0;
        end else begin
            r          = dec ? (d - k + 10) % 10 : (d + k) % 10;
            e.is_err   = 1'b0;
            e.res      = r[3:0];
            e.code     = tbl[r];
            e.busy_len = k + 1;
        end
        return e;
    endfunction

    // Monitor: compare every done/err against the scoreboard head.
    initial begin
        int   bcnt;
        bit   prev_done;
        exp_t e;
        bcnt      = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt      = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) begin
                    bcnt++;
                    chk("shift_result_range", 32'(result <= 4'd9), 32'd1);
                    if (result <= 4'd9) chk("shift_code_tracks_result", 32'(code), 32'(tbl[result]));
                end
                if (done) chk("done_single_cycle", 32'(prev_done), 32'd0);
                if (done || err) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: done=%0b err=%0b with no pending operation", done, err);
                    end else begin
                        e = sb.pop_front();
                        chk("event_kind_err", 32'(err), 32'(e.is_err));
                        chk("final_code", 32'(code), 32'(e.code));
                        chk("final_result", 32'(result), 32'(e.res));
                        chk("busy_cycles", 32'(bcnt), 32'(e.busy_len));
                    end
                    bcnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic wait_evt(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done || err) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done/err within %0d cycles", limit);
        end
    endtask

    task automatic run_op(input int d, input int k, input bit dec);
        bit got;
        sb.push_back(model(d, k, dec));
        @(negedge clk);
        start   = 1'b1;
        digit   = d[3:0];
        key     = k[3:0];
        decrypt = dec;
        @(posedge clk);
        #1;
        start   = 1'b0;
        digit   = 4'($urandom);
        key     = 4'($urandom);
        decrypt = 1'($urandom);
        wait_evt(20, got);
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed cases, start held high, reset mid-shift, then random operations.
    initial begin
        bit got;
        bit saw_done;
        rst = 1'b1; start = 1'b0; digit = 4'd0; key = 4'd0; decrypt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_code", 32'(code), 32'(5'b10000));
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        run_op(3, 4, 1'b0);
        run_op(8, 5, 1'b0);
        run_op(2, 7, 1'b1);
        run_op(9, 0, 1'b0);
        run_op(10, 3, 1'b0);
        run_op(4, 12, 1'b1);
        run_op(0, 9, 1'b1);
        run_op(9, 9, 1'b0);

        // start held high: the second operation may only begin in IDLE after DONE.
        sb.push_back(model(5, 2, 1'b1));
        sb.push_back(model(5, 2, 1'b1));
        @(negedge clk);
        start = 1'b1; digit = 4'd5; key = 4'd2; decrypt = 1'b1;
        wait_evt(20, got);
        @(negedge clk);
        chk("held_start_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("held_start_restart_busy", 32'(busy), 32'd1);
        wait_evt(20, got);
        start = 1'b0;
        @(posedge clk);
        #1;

        // Reset during SHIFT with a coincident start: the operation aborts and no done follows.
        @(negedge clk);
        start = 1'b1; digit = 4'd1; key = 4'd6; decrypt = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; digit = 4'd4; key = 4'd2;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("midrst_code", 32'(code), 32'(5'b10000));
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("midrst_no_activity", 32'(saw_done), 32'd0);

        run_op(6, 3, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
